// File: rtl/updown_cmd_generator.sv
// updown_cmd_generator: turns two raw, bouncing pushbuttons into single-cycle
// up/down command codes for the counter control unit.
// Each button passes through a two-flop synchronizer and a stability-counter
// debouncer. A press-detect FSM with conflict lockout then produces one
// registered pulse per accepted press: 01 = up, 10 = down, 00 = idle.
// Optional feature: define UPDOWN_AUTO_REPEAT_EN to re-issue the held
// button's command, first after REPEAT_DELAY cycles and then every
// REPEAT_RATE cycles.
module updown_cmd_generator #(
  parameter int unsigned DB_W            = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned REPEAT_DELAY    = 20000,
  parameter int unsigned REPEAT_RATE     = 5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [1:0] up_down,
  output logic [1:0] btn_state
);

  typedef enum logic [1:0] {
    IDLE,
    UP_HELD,
    DOWN_HELD,
    BOTH_LOCK
  } state_e;

  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_UP   = 2'b01;
  localparam logic [1:0] CMD_DOWN = 2'b10;

  // The counter holds DEBOUNCE_CYCLES-1 on the last mismatching cycle before
  // the level is accepted, so the toggle happens on that cycle's edge.
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Bit 0 is the up button, bit 1 the down button throughout.
  logic [1:0]           raw;
  logic [1:0]           sync1_q, sync2_q;
  logic [1:0]           level_q, level_d;
  logic [1:0]           level_prev_q;
  logic [1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]           rise;

  state_e               state_q, state_d;
  logic [1:0]           up_down_q, up_down_d;

  assign raw = {btn_down, btn_up};

  // Two-flop synchronizer; only sync2 is used downstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make sync2 take the previous sync1,
      // which is what gives two real flop stages.
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive disagreeing cycles, flip the level when the
  // count completes, and restart whenever the input agrees again.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    level_d  = level_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == level_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] >= DB_LAST) begin
        level_d[i]  = ~level_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
  end

  // Debounced levels, their one-cycle-old copy for rise detection, counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q      <= '0;
      level_prev_q <= '0;
      db_cnt_q     <= '0;
    end else begin
      level_q      <= level_d;
      level_prev_q <= level_q;
      db_cnt_q     <= db_cnt_d;
    end
  end

  assign rise = level_q & ~level_prev_q;

`ifdef UPDOWN_AUTO_REPEAT_EN
  localparam logic [DB_W-1:0] RPT_FIRST = DB_W'(REPEAT_DELAY - 1);
  localparam logic [DB_W-1:0] RPT_NEXT  = DB_W'(REPEAT_RATE - 1);

  logic [DB_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic            rpt_again_q, rpt_again_d;  // first repeat already issued
  logic            rpt_fire;

  assign rpt_fire = rpt_cnt_q >= (rpt_again_q ? RPT_NEXT : RPT_FIRST);
`else
  // Repeat timing has no effect without auto-repeat.
  logic unused_rpt_params;
  assign unused_rpt_params = ^{REPEAT_DELAY, REPEAT_RATE};
`endif

  // Press-detect FSM: next state and the command to register for next cycle.
  always_comb begin
    state_d   = state_q;
    up_down_d = CMD_NONE;
    case (state_q)
      IDLE: begin
        if (rise[0] && rise[1]) begin
          state_d = BOTH_LOCK;
        end else if (rise[0] && !level_q[1]) begin
          state_d   = UP_HELD;
          up_down_d = CMD_UP;
        end else if (rise[1] && !level_q[0]) begin
          state_d   = DOWN_HELD;
          up_down_d = CMD_DOWN;
        end
      end
      UP_HELD: begin
        if (level_q[1])       state_d = BOTH_LOCK;
        else if (!level_q[0]) state_d = IDLE;
`ifdef UPDOWN_AUTO_REPEAT_EN
        else if (rpt_fire)    up_down_d = CMD_UP;
`endif
      end
      DOWN_HELD: begin
        if (level_q[0])       state_d = BOTH_LOCK;
        else if (!level_q[1]) state_d = IDLE;
`ifdef UPDOWN_AUTO_REPEAT_EN
        else if (rpt_fire)    up_down_d = CMD_DOWN;
`endif
      end
      BOTH_LOCK: begin
        if (level_q == 2'b00) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef UPDOWN_AUTO_REPEAT_EN
  // Repeat timer: runs only while a held state persists, restarts on each
  // repeat pulse, and clears on any state change.
  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_again_d = rpt_again_q;
    if (!((state_q == UP_HELD) || (state_q == DOWN_HELD)) || (state_d != state_q)) begin
      rpt_cnt_d   = '0;
      rpt_again_d = 1'b0;
    end else if (rpt_fire) begin
      rpt_cnt_d   = '0;
      rpt_again_d = 1'b1;
    end else begin
      rpt_cnt_d = rpt_cnt_q + DB_W'(1);
    end
  end

  // Repeat timer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_cnt_q   <= '0;
      rpt_again_q <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_again_q <= rpt_again_d;
    end
  end
`endif

  // FSM state and the registered command output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      up_down_q <= CMD_NONE;
    end else begin
      state_q   <= state_d;
      up_down_q <= up_down_d;
    end
  end

  assign up_down   = up_down_q;
  assign btn_state = level_q;

endmodule
